// File: rtl/bp_io_cmd_router.sv
// Routes core I/O commands to channels_p endpoints by address and returns responses
// strictly in command order. Optional response timeout: BP_IO_CMD_ROUTER_TIMEOUT_EN.
module bp_io_cmd_router #(
   parameter int channels_p        = 2,
   parameter int msg_width_p       = 128,
   parameter int addr_width_p      = 40,
   parameter int addr_offset_p     = 0,
   parameter int sel_lsb_p         = 12,
   parameter int sel_width_p       = 3,
   parameter int outstanding_els_p = 4,
   parameter int timeout_cycles_p  = 1024
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [msg_width_p-1:0]            io_cmd_i,
   input  logic                              io_cmd_v_i,
   output logic                              io_cmd_ready_and_o,
   output logic [msg_width_p-1:0]            io_resp_o,
   output logic                              io_resp_v_o,
   input  logic                              io_resp_yumi_i,
   output logic [msg_width_p-1:0]            ch_cmd_o,
   output logic [channels_p-1:0]             ch_cmd_v_o,
   input  logic [channels_p-1:0]             ch_cmd_ready_and_i,
   input  logic [channels_p*msg_width_p-1:0] ch_resp_i,
   input  logic [channels_p-1:0]             ch_resp_v_i,
   output logic [channels_p-1:0]             ch_resp_yumi_o,
   output logic                              error_o
);
   localparam int ID_W  = (channels_p > 1) ? $clog2(channels_p) : 1;
   localparam int PTR_W = $clog2(outstanding_els_p);
   localparam int ENT_W = ID_W + 1;

   if (channels_p < 1 || channels_p > 8 || (1 << sel_width_p) < channels_p
       || sel_lsb_p + sel_width_p > addr_width_p || outstanding_els_p < 2
       || timeout_cycles_p < 2) begin : g_bad_params
      $error("bp_io_cmd_router: illegal parameter combination");
   end

   logic [sel_width_p-1:0] w_sel;
   logic [ID_W-1:0]        w_id;
   logic                   w_mapped;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_empty;
   logic [ENT_W-1:0]       w_head;
   logic [ID_W-1:0]        w_head_id;
   logic                   w_head_err;
   logic                   w_tmo;
   logic [channels_p-1:0]  w_drop_busy;
   logic [channels_p-1:0]  w_drop_yumi;
   logic [channels_p-1:0]  w_ch_cmd_v;
   logic [channels_p-1:0]  w_ch_yumi;
   logic                   w_resp_v;
   logic [msg_width_p-1:0] w_resp;
   logic [PTR_W-1:0]       w_wr_ptr_nxt;

   logic [ENT_W-1:0]       r_fifo [outstanding_els_p];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic                   r_full;
   logic                   r_error;

   assign w_sel    = io_cmd_i[addr_offset_p + sel_lsb_p +: sel_width_p];
   assign w_id     = w_sel[ID_W-1:0];
   assign w_mapped = (int'(w_sel) < channels_p);

   // Command path is purely combinational; the core sees ready only when a slot is free.
   always_comb begin
      w_ch_cmd_v = '0;
      if (!reset_i && w_mapped && io_cmd_v_i && !r_full) w_ch_cmd_v[w_id] = 1'b1;
   end

   assign ch_cmd_o           = io_cmd_i;
   assign ch_cmd_v_o         = w_ch_cmd_v;
   assign io_cmd_ready_and_o = ~reset_i & ~r_full & (~w_mapped | ch_cmd_ready_and_i[w_id]);
   assign w_push             = io_cmd_v_i & io_cmd_ready_and_o;

   assign w_empty    = (r_rd_ptr == r_wr_ptr) & ~r_full;
   assign w_head     = r_fifo[r_rd_ptr];
   assign w_head_id  = w_head[ID_W-1:0];
   assign w_head_err = w_head[ID_W];

   always_comb begin
      w_resp_v  = 1'b0;
      w_resp    = '0;
      w_ch_yumi = w_drop_yumi;
      if (!w_empty) begin
         if (w_head_err || w_tmo) begin
            w_resp_v = 1'b1;
         end else if (!w_drop_busy[w_head_id]) begin
            w_resp_v             = ch_resp_v_i[w_head_id];
            w_resp               = ch_resp_i[int'(w_head_id)*msg_width_p +: msg_width_p];
            w_ch_yumi[w_head_id] = io_resp_yumi_i;
         end
      end
   end

   assign io_resp_v_o    = w_resp_v;
   assign io_resp_o      = w_resp;
   assign ch_resp_yumi_o = w_ch_yumi;
   assign w_pop          = io_resp_yumi_i & w_resp_v;
   assign w_wr_ptr_nxt   = r_wr_ptr + 1'b1;

   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_mapped ? {1'b0, w_id} : {1'b1, {ID_W{1'b0}}};
   end

   // Pointers wrap naturally; r_full disambiguates equal pointers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop && (w_wr_ptr_nxt == r_rd_ptr)) r_full <= 1'b1;
         else if (w_pop && !w_push)                          r_full <= 1'b0;
         if ((w_push && !w_mapped) || (w_pop && w_tmo)) r_error <= 1'b1;
      end
   end

   assign error_o = r_error;

`ifdef BP_IO_CMD_ROUTER_TIMEOUT_EN
   localparam int TMO_W  = $clog2(timeout_cycles_p);
   localparam int DROP_W = $clog2(outstanding_els_p + 1);

   logic [TMO_W-1:0]  r_tmo_cnt;
   logic [DROP_W-1:0] r_drop_cnt [channels_p];
   logic [DROP_W-1:0] w_drop_nxt [channels_p];
   logic              w_tmo_max;

   assign w_tmo_max = (r_tmo_cnt == TMO_W'(timeout_cycles_p - 1));
   assign w_tmo     = ~w_empty & ~w_head_err & w_tmo_max;

   // A timed-out channel owes one stale response per drop; those are swallowed on arrival.
   always_comb begin
      for (int k = 0; k < channels_p; k++) begin
         w_drop_busy[k] = (r_drop_cnt[k] != '0);
         w_drop_yumi[k] = w_drop_busy[k] & ch_resp_v_i[k];
         w_drop_nxt[k]  = r_drop_cnt[k];
         if (w_pop && w_tmo && (w_head_id == ID_W'(k))
             && (r_drop_cnt[k] != DROP_W'(outstanding_els_p)))
            w_drop_nxt[k] = w_drop_nxt[k] + 1'b1;
         if (w_drop_yumi[k]) w_drop_nxt[k] = w_drop_nxt[k] - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_tmo_cnt <= '0;
         for (int k = 0; k < channels_p; k++) r_drop_cnt[k] <= '0;
      end else begin
         if (w_empty || w_pop) r_tmo_cnt <= '0;
         else if (!w_tmo_max)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
         for (int k = 0; k < channels_p; k++) r_drop_cnt[k] <= w_drop_nxt[k];
      end
   end
`else
   assign w_tmo       = 1'b0;
   assign w_drop_busy = '0;
   assign w_drop_yumi = '0;
`endif

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(io_resp_yumi_i && !io_resp_v_o));

endmodule

// File: tb/tb_bp_io_cmd_router.sv
// Self-checking bench for bp_io_cmd_router: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bp_io_cmd_router;
   localparam int CH = 2;
   localparam int MW = 128;
   localparam int OE = 4;
`ifdef BP_IO_CMD_ROUTER_TIMEOUT_EN
   localparam int TMO    = 16;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 1024;
   localparam bit TMO_EN = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [MW-1:0]     io_cmd_i;
   logic              io_cmd_v_i;
   logic              io_cmd_ready_and_o;
   logic [MW-1:0]     io_resp_o;
   logic              io_resp_v_o;
   logic              io_resp_yumi_i;
   logic [MW-1:0]     ch_cmd_o;
   logic [CH-1:0]     ch_cmd_v_o;
   logic [CH-1:0]     ch_cmd_ready_and_i;
   logic [CH*MW-1:0]  ch_resp_i;
   logic [CH-1:0]     ch_resp_v_i;
   logic [CH-1:0]     ch_resp_yumi_o;
   logic              error_o;

   always #5 clk_i = ~clk_i;

   bp_io_cmd_router #(
      .channels_p(CH), .msg_width_p(MW), .addr_width_p(40), .addr_offset_p(0),
      .sel_lsb_p(12), .sel_width_p(3), .outstanding_els_p(OE), .timeout_cycles_p(TMO)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_and_o(io_cmd_ready_and_o),
      .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
      .ch_cmd_o(ch_cmd_o), .ch_cmd_v_o(ch_cmd_v_o), .ch_cmd_ready_and_i(ch_cmd_ready_and_i),
      .ch_resp_i(ch_resp_i), .ch_resp_v_i(ch_resp_v_i), .ch_resp_yumi_o(ch_resp_yumi_o),
      .error_o(error_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [MW-1:0] mk(input logic [39:0] addr, input logic [15:0] tag);
      logic [MW-1:0] m;
      m          = '0;
      m[39:0]    = addr;
      m[127:112] = tag;
      return m;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_resp(input int k, input logic [MW-1:0] d, input logic v);
      ch_resp_i[k*MW +: MW] = d;
      ch_resp_v_i[k]        = v;
   endtask

   // Reference model: outstanding commands as a queue of {err, channel}.
   typedef struct { bit err; int id; } ent_t;
   ent_t q[$];
   bit   m_err;
   int   m_tmo;
   int   m_drop [CH];

   always @(negedge clk_i) begin : cmp
      int            sel, hid;
      bit            mapped, full, e_ready, e_rv, synth, pop, push;
      logic [CH-1:0] e_cmdv, e_yumi, dyumi;
      logic [MW-1:0] e_resp;
      if (reset_i) begin
         chk("rst_ready", io_cmd_ready_and_o, 0);
         chk("rst_resp_v", io_resp_v_o, 0);
         chk("rst_cmd_v", ch_cmd_v_o, 0);
         chk("rst_yumi", ch_resp_yumi_o, 0);
         chk("rst_error", error_o, 0);
         q.delete();
         m_err = 0;
         m_tmo = 0;
         for (int k = 0; k < CH; k++) m_drop[k] = 0;
      end else begin
         sel     = int'(io_cmd_i[14:12]);
         mapped  = sel < CH;
         full    = q.size() == OE;
         e_ready = !full && (!mapped || ch_cmd_ready_and_i[sel]);
         e_cmdv  = '0;
         if (mapped && io_cmd_v_i && !full) e_cmdv[sel] = 1'b1;
         for (int k = 0; k < CH; k++) dyumi[k] = (m_drop[k] > 0) && ch_resp_v_i[k];
         e_yumi = dyumi;
         e_rv   = 0;
         e_resp = '0;
         synth  = 0;
         hid    = 0;
         if (q.size() > 0) begin
            hid = q[0].id;
            if (q[0].err || (TMO_EN && m_tmo == TMO - 1)) begin
               e_rv  = 1;
               synth = !q[0].err;
            end else if (m_drop[hid] == 0) begin
               e_rv        = ch_resp_v_i[hid];
               e_resp      = ch_resp_i[hid*MW +: MW];
               e_yumi[hid] = io_resp_yumi_i;
            end
         end
         chk("m_ready", io_cmd_ready_and_o, e_ready);
         chk("m_cmd_v", ch_cmd_v_o, e_cmdv);
         chk("m_cmd_data", ch_cmd_o, io_cmd_i);
         chk("m_resp_v", io_resp_v_o, e_rv);
         if (e_rv) chk("m_resp_data", io_resp_o, e_resp);
         chk("m_resp_yumi", ch_resp_yumi_o, e_yumi);
         chk("m_error", error_o, m_err);
         pop  = io_resp_yumi_i && e_rv;
         push = io_cmd_v_i && e_ready;
         if (q.size() == 0 || pop) m_tmo = 0;
         else if (m_tmo < TMO - 1) m_tmo++;
         if (pop) begin
            if (synth) begin
               m_err = 1;
               if (m_drop[hid] < OE) m_drop[hid]++;
            end
            void'(q.pop_front());
         end
         for (int k = 0; k < CH; k++) if (dyumi[k]) m_drop[k]--;
         if (push) begin
            q.push_back('{err: !mapped, id: mapped ? sel : 0});
            if (!mapped) m_err = 1;
         end
      end
   end

   initial begin
      reset_i            = 1'b1;
      io_cmd_i           = '0;
      io_cmd_v_i         = 1'b0;
      io_resp_yumi_i     = 1'b0;
      ch_cmd_ready_and_i = 2'b11;
      ch_resp_i          = '0;
      ch_resp_v_i        = '0;
      repeat (3) @(negedge clk_i);
      step();
      reset_i = 1'b0;

      // idle: ready follows channel 0's ready (address 0 decodes to channel 0)
      @(negedge clk_i);
      chk("idle_ready", io_cmd_ready_and_o, 1);
      chk("idle_resp_v", io_resp_v_o, 0);
      step();
      ch_cmd_ready_and_i = 2'b10;
      @(negedge clk_i);
      chk("idle_ready_follow", io_cmd_ready_and_o, 0);
      step();
      ch_cmd_ready_and_i = 2'b11;

      // routing: 0x0010_1000 -> channel 1, response 3 cycles later
      step();
      io_cmd_i   = mk(40'h00_0010_1000, 16'hA1);
      io_cmd_v_i = 1'b1;
      @(negedge clk_i);
      chk("route_cmd_v", ch_cmd_v_o, 2'b10);
      chk("route_ready", io_cmd_ready_and_o, 1);
      step();
      io_cmd_v_i = 1'b0;
      io_cmd_i   = '0;
      step();
      step();
      set_resp(1, 128'hD1D1_0000_0000_0000_0000_0000_0000_0001, 1'b1);
      io_resp_yumi_i = 1'b1;
      @(negedge clk_i);
      chk("route_resp_v", io_resp_v_o, 1);
      chk("route_resp", io_resp_o, 128'hD1D1_0000_0000_0000_0000_0000_0000_0001);
      chk("route_yumi", ch_resp_yumi_o, 2'b10);
      step();
      set_resp(1, '0, 1'b0);
      io_resp_yumi_i = 1'b0;

      // ordering: ch0 then ch1; ch1 answers first but must wait
      step();
      io_cmd_i   = mk(40'h0, 16'hB0);
      io_cmd_v_i = 1'b1;
      step();
      io_cmd_i = mk(40'h1000, 16'hB1);
      step();
      io_cmd_v_i = 1'b0;
      io_cmd_i   = '0;
      set_resp(1, 128'hB1, 1'b1);
      for (int c = 2; c < 5; c++) begin
         @(negedge clk_i);
         chk("order_ch1_held", ch_resp_yumi_o, 2'b00);
         chk("order_no_resp", io_resp_v_o, 0);
         step();
      end
      set_resp(0, 128'hB0, 1'b1);
      io_resp_yumi_i = 1'b1;
      @(negedge clk_i);
      chk("order_first", io_resp_o, 128'hB0);
      chk("order_first_yumi", ch_resp_yumi_o, 2'b01);
      step();
      set_resp(0, '0, 1'b0);
      @(negedge clk_i);
      chk("order_second", io_resp_o, 128'hB1);
      chk("order_second_yumi", ch_resp_yumi_o, 2'b10);
      step();
      set_resp(1, '0, 1'b0);
      io_resp_yumi_i = 1'b0;

      // full: four outstanding, fifth stalls; pop does not bypass
      for (int i = 0; i < 4; i++) begin
         step();
         io_cmd_i   = mk(40'h0, 16'(16'hC0 + i));
         io_cmd_v_i = 1'b1;
         @(negedge clk_i);
         chk("fill_ready", io_cmd_ready_and_o, 1);
      end
      step();
      io_cmd_i = mk(40'h0, 16'hC4);
      @(negedge clk_i);
      chk("full_ready", io_cmd_ready_and_o, 0);
      step();
      set_resp(0, 128'hC0, 1'b1);
      io_resp_yumi_i = 1'b1;
      @(negedge clk_i);
      chk("full_pop_no_bypass", io_cmd_ready_and_o, 0);
      step();
      set_resp(0, '0, 1'b0);
      io_resp_yumi_i = 1'b0;
      @(negedge clk_i);
      chk("full_ready_back", io_cmd_ready_and_o, 1);
      step();
      io_cmd_v_i = 1'b0;
      io_cmd_i   = '0;
      set_resp(0, 128'hC1, 1'b1);
      io_resp_yumi_i = 1'b1;
      repeat (4) step();
      set_resp(0, '0, 1'b0);
      io_resp_yumi_i = 1'b0;
      ch_cmd_ready_and_i = 2'b10;
      @(negedge clk_i);
      chk("bp_ch0_ready", io_cmd_ready_and_o, 0);
      step();
      io_cmd_i = mk(40'h1000, 16'h0);
      @(negedge clk_i);
      chk("bp_ch1_ready", io_cmd_ready_and_o, 1);
      step();
      io_cmd_i           = '0;
      ch_cmd_ready_and_i = 2'b11;

      // unmapped: sel=5 accepted, zero response in order, sticky error
      step();
      io_cmd_i   = mk(40'h1000, 16'hE1);
      io_cmd_v_i = 1'b1;
      step();
      io_cmd_i = mk(40'h5000, 16'hE5);
      @(negedge clk_i);
      chk("unmap_ready", io_cmd_ready_and_o, 1);
      chk("unmap_cmd_v", ch_cmd_v_o, 2'b00);
      step();
      io_cmd_v_i = 1'b0;
      io_cmd_i   = '0;
      @(negedge clk_i);
      chk("unmap_error", error_o, 1);
      chk("unmap_head_waits", io_resp_v_o, 0);
      step();
      set_resp(1, 128'hE1, 1'b1);
      io_resp_yumi_i = 1'b1;
      @(negedge clk_i);
      chk("unmap_prior_resp", io_resp_o, 128'hE1);
      step();
      set_resp(1, '0, 1'b0);
      @(negedge clk_i);
      chk("unmap_resp_v", io_resp_v_o, 1);
      chk("unmap_resp_zero", io_resp_o, '0);
      step();
      io_resp_yumi_i = 1'b0;
      repeat (3) step();
      @(negedge clk_i);
      chk("unmap_error_sticky", error_o, 1);
      // reset with an entry outstanding discards it
      step();
      io_cmd_i   = mk(40'h1000, 16'hF1);
      io_cmd_v_i = 1'b1;
      step();
      io_cmd_v_i = 1'b0;
      io_cmd_i   = '0;
      reset_i    = 1'b1;
      @(negedge clk_i);
      chk("reset_clears_error", error_o, 0);
      step();
      reset_i = 1'b0;
      set_resp(1, 128'hF1, 1'b1);
      @(negedge clk_i);
      chk("reset_discard", io_resp_v_o, 0);
      step();
      set_resp(1, '0, 1'b0);

`ifdef BP_IO_CMD_ROUTER_TIMEOUT_EN
      begin
         int c;
         step();
         io_cmd_i   = mk(40'h0, 16'h70);
         io_cmd_v_i = 1'b1;
         step();
         io_cmd_v_i = 1'b0;
         io_cmd_i   = '0;
         c = 1;
         while (c <= 40) begin
            @(negedge clk_i);
            if (io_resp_v_o) break;
            step();
            c++;
         end
         chk("tmo_cycle", 128'(c), 128'd16);
         chk("tmo_resp_zero", io_resp_o, '0);
         chk("tmo_error_before", error_o, 0);
      end
      step();
      io_resp_yumi_i = 1'b1;
      step();
      io_resp_yumi_i = 1'b0;
      @(negedge clk_i);
      chk("tmo_error", error_o, 1);
      step();
      set_resp(0, 128'h7777, 1'b1);
      @(negedge clk_i);
      chk("tmo_drop_yumi", ch_resp_yumi_o, 2'b01);
      chk("tmo_drop_hidden", io_resp_v_o, 0);
      step();
      set_resp(0, '0, 1'b0);
      io_cmd_i   = mk(40'h0, 16'h71);
      io_cmd_v_i = 1'b1;
      step();
      io_cmd_v_i = 1'b0;
      io_cmd_i   = '0;
      set_resp(0, 128'h71, 1'b1);
      io_resp_yumi_i = 1'b1;
      @(negedge clk_i);
      chk("tmo_after_resp", io_resp_o, 128'h71);
      chk("tmo_after_yumi", ch_resp_yumi_o, 2'b01);
      step();
      set_resp(0, '0, 1'b0);
      io_resp_yumi_i = 1'b0;
`endif

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
